// File: rtl/wb_regfile.sv
// Writeback-stage register file: 16 x N registers with an optional PC alias on
// register 15, same-cycle write-to-read bypass on both read ports, and a small
// amount of retirement bookkeeping (commit counter and last destination index).
module wb_regfile #(
  parameter int N      = 32,
  parameter int R15_PC = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         RF_WE_i,
  input  logic         WBSelect_i,
  input  logic [N-1:0] ReadData_i,
  input  logic [N-1:0] AluResult_i,
  input  logic [3:0]   A3_i,
  input  logic [3:0]   A1_i,
  input  logic [3:0]   A2_i,
  input  logic [N-1:0] PC8_i,
  output logic [N-1:0] RD1_o,
  output logic [N-1:0] RD2_o,
  output logic [N-1:0] WD3_o,
  output logic [N-1:0] RetireCnt_o,
  output logic [3:0]   LastA3_o,
  output logic         LastValid_o
);

  localparam logic [3:0] PC_IDX = 4'd15;

  logic [N-1:0] regs [16];
  logic         pc_alias_on;
  logic         wr_dropped;
  logic         wr_commit;

  assign pc_alias_on = (R15_PC != 0);

  // A write aimed at the aliased PC slot is counted but never stored.
  assign wr_dropped = pc_alias_on && (A3_i == PC_IDX);
  assign wr_commit  = RF_WE_i && !wr_dropped;

  // Writeback source select, visible regardless of the write enable.
  always_comb begin
    WD3_o = WBSelect_i ? ReadData_i : AluResult_i;
  end

  // Read port 1: PC alias first, then same-cycle bypass, then stored value.
  always_comb begin
    RD1_o = regs[A1_i];
    if (pc_alias_on && (A1_i == PC_IDX)) begin
      RD1_o = PC8_i;
    end else if (wr_commit && (A1_i == A3_i)) begin
      RD1_o = WD3_o;
    end
  end

  // Read port 2: same priority as port 1, evaluated independently.
  always_comb begin
    RD2_o = regs[A2_i];
    if (pc_alias_on && (A2_i == PC_IDX)) begin
      RD2_o = PC8_i;
    end else if (wr_commit && (A2_i == A3_i)) begin
      RD2_o = WD3_o;
    end
  end

  // Register storage: cleared asynchronously, written on committed writebacks.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[A3_i] <= WD3_o;
    end
  end

  // Retirement bookkeeping: every enabled writeback counts, dropped ones too.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RetireCnt_o <= '0;
      LastA3_o    <= '0;
      LastValid_o <= 1'b0;
    end else if (RF_WE_i) begin
      RetireCnt_o <= RetireCnt_o + N'(1);
      LastA3_o    <= A3_i;
      LastValid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a 32-bit instance with the PC alias and an 8-bit
// instance without it share one stimulus stream; a behavioural model of the
// register file is compared against both every cycle, and directed sequences
// pin the model with hand-computed values.
module tb_wb_regfile;

  logic        CLK = 1'b0;
  logic        RST;
  logic        we, sel;
  logic [31:0] rdata, alu, pc8;
  logic [3:0]  a1, a2, a3;

  logic [31:0] rd1, rd2, wd3, cnt;
  logic [3:0]  la;
  logic        lv;
  logic [7:0]  s_rd1, s_rd2, s_wd3, s_cnt;
  logic [3:0]  s_la;
  logic        s_lv;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_reg [16];
  logic [7:0]  s_reg [16];
  logic [31:0] m_cnt;
  logic [7:0]  s_cnt_m;
  logic [3:0]  m_la;
  logic        m_lv;

  always #5 CLK = ~CLK;

  wb_regfile #(.N(32), .R15_PC(1)) u_big (
    .CLK(CLK), .RST(RST), .RF_WE_i(we), .WBSelect_i(sel),
    .ReadData_i(rdata), .AluResult_i(alu), .A3_i(a3), .A1_i(a1), .A2_i(a2),
    .PC8_i(pc8), .RD1_o(rd1), .RD2_o(rd2), .WD3_o(wd3),
    .RetireCnt_o(cnt), .LastA3_o(la), .LastValid_o(lv)
  );

  wb_regfile #(.N(8), .R15_PC(0)) u_small (
    .CLK(CLK), .RST(RST), .RF_WE_i(we), .WBSelect_i(sel),
    .ReadData_i(rdata[7:0]), .AluResult_i(alu[7:0]), .A3_i(a3), .A1_i(a1),
    .A2_i(a2), .PC8_i(pc8[7:0]), .RD1_o(s_rd1), .RD2_o(s_rd2), .WD3_o(s_wd3),
    .RetireCnt_o(s_cnt), .LastA3_o(s_la), .LastValid_o(s_lv)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_wd();
    return sel ? rdata : alu;
  endfunction

  // 32-bit instance: R15 reads PC+8, writes to R15 never land or bypass.
  function automatic logic [31:0] exp_big(input logic [3:0] a);
    if (a == 4'd15) return pc8;
    if (we && (a == a3)) return exp_wd();
    return m_reg[a];
  endfunction

  // 8-bit instance: plain 16-entry file, R15 is an ordinary register.
  function automatic logic [7:0] exp_small(input logic [3:0] a);
    logic [31:0] w;
    w = exp_wd();
    if (we && (a == a3)) return w[7:0];
    return s_reg[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_reg[i] = '0;
      s_reg[i] = '0;
    end
    m_cnt   = '0;
    s_cnt_m = '0;
    m_la    = '0;
    m_lv    = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] w;
    w = exp_wd();
    if (RST && we) begin
      m_cnt   = m_cnt + 32'd1;
      s_cnt_m = s_cnt_m + 8'd1;
      m_la    = a3;
      m_lv    = 1'b1;
      if (a3 != 4'd15) m_reg[a3] = w;
      s_reg[a3] = w[7:0];
    end
  endtask

  task automatic compare_all();
    logic [31:0] w;
    w = exp_wd();
    check("big_rd1", rd1, exp_big(a1));
    check("big_rd2", rd2, exp_big(a2));
    check("big_wd3", wd3, w);
    check("big_cnt", cnt, m_cnt);
    check("big_last_a3", {28'd0, la}, {28'd0, m_la});
    check("big_last_valid", {31'd0, lv}, {31'd0, m_lv});
    check("small_rd1", {24'd0, s_rd1}, {24'd0, exp_small(a1)});
    check("small_rd2", {24'd0, s_rd2}, {24'd0, exp_small(a2)});
    check("small_wd3", {24'd0, s_wd3}, {24'd0, w[7:0]});
    check("small_cnt", {24'd0, s_cnt}, {24'd0, s_cnt_m});
    check("small_last_a3", {28'd0, s_la}, {28'd0, m_la});
    check("small_last_valid", {31'd0, s_lv}, {31'd0, m_lv});
  endtask

  task automatic drive(input logic w, input logic s, input logic [31:0] r,
                       input logic [31:0] al, input logic [3:0] d,
                       input logic [3:0] x, input logic [3:0] y,
                       input logic [31:0] p);
    we = w; sel = s; rdata = r; alu = al; a3 = d; a1 = x; a2 = y; pc8 = p;
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cycle();
    @(negedge CLK);
    compare_all();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  initial begin
    RST = 1'b0;
    model_clear();
    drive(1'b1, 1'b0, 32'h0, 32'h77, 4'd1, 4'd1, 4'd0, 32'h0);
    #1;
    check("reset_cnt", cnt, 32'h0);
    check("reset_valid", {31'd0, lv}, 32'h0);
    check("reset_bypass", rd1, 32'h77);
    check("reset_r0", rd2, 32'h0);
    cycle();
    cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd1, 4'd1, 4'd0, 32'h0);
    #1;
    check("reset_write_ignored", rd1, 32'h0);
    RST = 1'b1;

    // basic write then read
    drive(1'b1, 1'b0, 32'h0, 32'h0000_00A5, 4'd3, 4'd0, 4'd0, 32'h108);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd3, 4'd0, 32'h108);
    #1;
    check("basic_rd1", rd1, 32'h0000_00A5);
    check("basic_cnt", cnt, 32'd1);
    check("basic_last_a3", {28'd0, la}, 32'd3);
    check("basic_valid", {31'd0, lv}, 32'd1);
    cycle();

    // load bypass on both ports
    drive(1'b1, 1'b0, 32'h0, 32'h11, 4'd4, 4'd0, 4'd0, 32'h108);
    cycle();
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0, 4'd4, 4'd4, 4'd4, 32'h108);
    #1;
    check("bypass_rd1", rd1, 32'hDEAD_BEEF);
    check("bypass_rd2", rd2, 32'hDEAD_BEEF);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd4, 4'd0, 32'h108);
    #1;
    check("bypass_stored", rd1, 32'hDEAD_BEEF);
    cycle();

    // R15 alias: write dropped, no bypass, still counted
    drive(1'b1, 1'b0, 32'h0, 32'h55, 4'd15, 4'd15, 4'd15, 32'h0000_0108);
    #1;
    check("r15_no_bypass", rd1, 32'h0000_0108);
    check("r15_small_bypass", {24'd0, s_rd1}, 32'h55);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd15, 4'd0, 32'h0000_0108);
    #1;
    check("r15_alias", rd1, 32'h0000_0108);
    check("r15_cnt", cnt, 32'd4);
    check("r15_last_a3", {28'd0, la}, 32'd15);
    cycle();

    // back-to-back writes to R2
    drive(1'b1, 1'b0, 32'h0, 32'h1, 4'd2, 4'd2, 4'd0, 32'h108);
    #1;
    check("b2b_first", rd1, 32'h1);
    cycle();
    drive(1'b1, 1'b0, 32'h0, 32'h2, 4'd2, 4'd2, 4'd0, 32'h108);
    #1;
    check("b2b_second", rd1, 32'h2);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd2, 4'd0, 32'h108);
    #1;
    check("b2b_final", rd1, 32'h2);
    check("b2b_cnt", cnt, 32'd6);
    cycle();

    // reset mid-operation, between edges
    drive(1'b1, 1'b0, 32'h0, 32'h1234, 4'd7, 4'd0, 4'd0, 32'h108);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd7, 4'd0, 32'h108);
    #1;
    check("pre_reset_r7", rd1, 32'h1234);
    RST = 1'b0;
    #1;
    model_clear();
    check("async_r7", rd1, 32'h0);
    check("async_cnt", cnt, 32'h0);
    check("async_valid", {31'd0, lv}, 32'h0);
    check("async_last_a3", {28'd0, la}, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF, 4'd7, 4'd7, 4'd0, 32'h108);
    #1;
    check("reset_bypass_r7", rd1, 32'hFFFF);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd7, 4'd0, 32'h108);
    #1;
    check("reset_no_commit", rd1, 32'h0);
    check("reset_no_count", cnt, 32'h0);
    cycle();
    RST = 1'b1;

    // counter wrap on the 8-bit instance
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, 1'($urandom), $urandom, $urandom, 4'($urandom),
            4'($urandom), 4'($urandom), $urandom);
      cycle();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 32'h108);
    #1;
    check("wrap_small_full", {24'd0, s_cnt}, 32'hFF);
    check("wrap_big_255", cnt, 32'd255);
    cycle();
    drive(1'b1, 1'b0, 32'h0, 32'h9, 4'd5, 4'd0, 4'd0, 32'h108);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 32'h108);
    #1;
    check("wrap_small_zero", {24'd0, s_cnt}, 32'h0);
    check("wrap_big_256", cnt, 32'd256);
    cycle();

    // randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] d, x, y;
      d = 4'($urandom);
      x = ($urandom_range(0, 3) == 0) ? d : 4'($urandom);
      y = ($urandom_range(0, 3) == 0) ? d : 4'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        RST = 1'b0;
        model_clear();
      end else begin
        RST = 1'b1;
      end
      drive(($urandom_range(0, 9) < 7), 1'($urandom), $urandom, $urandom,
            d, x, y, $urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter N, default 32, data width of the register file and all data ports.
REQ-002 SHALL have parameter R15_PC, default 1; when 1, register 15 is the PC alias per REQ-014/REQ-015.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset; asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port RF_WE_i  input  1  writeback enable from the MEM/WB stage.
REQ-006 SHALL have port WBSelect_i  input  1  writeback source: 1 = ReadData_i, 0 = AluResult_i.
REQ-007 SHALL have port ReadData_i  input  N  data-memory load result from the MEM/WB stage.
REQ-008 SHALL have port AluResult_i  input  N  ALU result from the MEM/WB stage.
REQ-009 SHALL have port A3_i  input  4  destination register index.
REQ-010 SHALL have ports A1_i, A2_i  input  4 each  decode-stage read indices.
REQ-011 SHALL have port PC8_i  input  N  current PC+8, returned for reads of register 15.
REQ-012 SHALL have ports RD1_o, RD2_o  output  N each  read data for A1_i and A2_i; WD3_o  output  N  selected writeback value; RetireCnt_o  output  N  count of committed writes; LastA3_o  output  4  last committed destination; LastValid_o  output  1  LastA3_o holds a valid index.

Function
REQ-013 SHALL drive WD3_o combinationally as WBSelect_i ? ReadData_i : AluResult_i, independent of RF_WE_i.
REQ-014 SHALL hold 16 registers of N bits; on a CLK rising edge with RF_WE_i=1, SHALL write WD3_o to register A3_i, except A3_i=15 with R15_PC=1, where the write is dropped.
REQ-015 SHALL read combinationally: RDk_o = PC8_i if Ak_i=15 and R15_PC=1; otherwise the stored register value, subject to REQ-016.
REQ-016 SHALL bypass same-cycle writes: if RF_WE_i=1, Ak_i=A3_i, and the write is not dropped, RDk_o = WD3_o; both ports bypass independently and may bypass simultaneously.
REQ-017 SHALL increment RetireCnt_o by 1 on each rising edge with RF_WE_i=1, including dropped R15 writes; it wraps from 2^N-1 to 0 with no flag.
REQ-018 SHALL, on each rising edge with RF_WE_i=1, load LastA3_o with A3_i and set LastValid_o to 1; with RF_WE_i=0, both hold.
REQ-019 SHALL update all state in the cycle the write is presented; write latency is one edge, and bypass removes the read-after-write bubble.
REQ-020 SHALL treat the inputs as already registered by the MEM/WB stage; no input retiming.
REQ-021 SHALL perform no arithmetic on data other than the counter; counter width is exactly N.

Reset
REQ-022 SHALL, while RST=0, clear all 16 registers, RetireCnt_o, LastA3_o, and LastValid_o to 0 asynchronously, without waiting for CLK.
REQ-023 SHALL ignore RF_WE_i while RST=0; a write presented on the edge at which RST=0 does not commit.
REQ-024 SHALL resume normal operation on the first CLK rising edge after RST returns to 1.
REQ-025 SHALL keep combinational paths (WD3_o, RDk_o, bypass, PC alias) active during reset, with reads of R0-R14 returning 0.

Verification
REQ-026 SHALL cover basic write/read: RF_WE=1, WBSelect=0, AluResult=0x0000_00A5, A3=3, edge; then A1=3, RF_WE=0 -> RD1_o=0x0000_00A5, RetireCnt_o=1, LastA3_o=3, LastValid_o=1.
REQ-027 SHALL cover load bypass: R4=0x11; present RF_WE=1, WBSelect=1, ReadData=0xDEAD_BEEF, A3=4, with A1=A2=4 before the edge -> RD1_o=RD2_o=0xDEAD_BEEF same cycle; after the edge R4=0xDEAD_BEEF.
REQ-028 SHALL cover the R15 alias: PC8=0x0000_0108; write 0x55 to A3=15 -> RD1_o for A1=15 stays 0x0000_0108, no bypass, RetireCnt_o increments, LastA3_o=15.
REQ-029 SHALL cover counter wrap: force RetireCnt_o=0xFFFF_FFFF via 2^32-1 writes or a preload test hook; one more write -> 0x0000_0000.
REQ-030 SHALL cover reset mid-operation: write R7=0x1234 and RetireCnt=5; drop RST to 0 between edges -> RD for A1=7 reads 0 immediately, RetireCnt_o=0, LastValid_o=0; an RF_WE=1 edge during reset leaves everything 0.
REQ-031 SHALL cover back-to-back writes to one index: R2<-0x1 then R2<-0x2 on consecutive edges, with A1=2 throughout -> RD1_o shows 0x1 then 0x2 in the presenting cycles; final R2=0x2, RetireCnt_o=2.
